dram_port_arbiter: RTL and testbench

//   Shares one single-port DRAM instance (combinational read, posedge write) between two

---
 rtl/dram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port DRAM (combinational read,
// posedge write). Registered responses with backpressure, bounded RMW lock.
module dram_port_arbiter #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned LOCK_MAX  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0]             req_lock,
    input  logic [2*ADDR_BITS-1:0] req_addr,
    input  logic [63:0]            req_wdata,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [63:0]            rsp_rdata,
    output logic [ADDR_BITS-1:0]   mem_a,
    output logic                   mem_we,
    output logic [31:0]            mem_d,
    input  logic [31:0]            mem_spo,
    output logic                   lock_timeout
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED0 = 2'd1,
        LOCKED1 = 2'd2
    } lock_state_e;

    lock_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               last_q, last_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               timeout_q, timeout_d;

    logic [1:0]         lock_ok;
    logic [1:0]         elig;
    logic [1:0]         grant;
    logic               accept;
    logic               sel;

    // Eligibility and round-robin grant; nothing is granted while reset is asserted.
    always_comb begin
        lock_ok = 2'b11;
        grant   = 2'b00;
        case (state_q)
            LOCKED0: lock_ok = 2'b01;
            LOCKED1: lock_ok = 2'b10;
            default: lock_ok = 2'b11;
        endcase
        elig = req_valid & ~(rsp_valid_q & ~rsp_ready) & lock_ok;
        if (rst_n) begin
            if (elig == 2'b11) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel       = grant[1];

    // DRAM port mux: idle bus is all zeros.
    always_comb begin
        mem_a  = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        if (accept) begin
            if (sel) begin
                mem_a  = req_addr[ADDR_BITS +: ADDR_BITS];
                mem_d  = req_wdata[DATA_W +: DATA_W];
                mem_we = req_we[1];
            end else begin
                mem_a  = req_addr[0 +: ADDR_BITS];
                mem_d  = req_wdata[0 +: DATA_W];
                mem_we = req_we[0];
            end
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next state: response slots, last grant, lock FSM with idle-cycle timeout.
    always_comb begin
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rdata_d     = rdata_q;
        last_d      = last_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;

        if (grant[0]) begin
            rsp_valid_d[0]          = 1'b1;
            rdata_d[0 +: DATA_W]    = mem_spo;
        end
        if (grant[1]) begin
            rsp_valid_d[1]          = 1'b1;
            rdata_d[DATA_W +: DATA_W] = mem_spo;
        end
        if (accept) begin
            last_d = sel;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept && req_lock[sel]) begin
                    state_d = sel ? LOCKED1 : LOCKED0;
                end
            end
            LOCKED0, LOCKED1: begin
                if (accept) begin
                    cnt_d = '0;
                    if (!req_lock[sel]) begin
                        state_d = IDLE;
                    end
                end else if (cnt_inc == CNT_W'(LOCK_MAX)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    last_d    = (state_q == LOCKED1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            rsp_valid_q <= 2'b00;
            rdata_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            timeout_q   <= timeout_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign lock_timeout = timeout_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: DRAM model, cycle-level behavioural reference and
// directed scenarios with literal expectations.
module tb_dram_port_arbiter;

    localparam int unsigned AW   = 16;
    localparam int unsigned LMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid, req_ready, req_we, req_lock;
    logic [2*AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic [1:0]    rsp_valid, rsp_ready;
    logic [63:0]   rsp_rdata;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [31:0]   mem_d, mem_spo;
    logic          lock_timeout;

    int checks = 0;
    int errors = 0;

    dram_port_arbiter #(.ADDR_BITS(AW), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_spo(mem_spo),
        .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    // DRAM: combinational read, posedge write.
    logic [31:0] dram [256];
    assign mem_spo = dram[mem_a[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) dram[i] <= 32'h0;
        dram[8'h10] <= 32'hDEADBEEF;
        dram[8'h11] <= 32'h0BADF00D;
        dram[8'h30] <= 32'h00000041;
        forever begin
            @(posedge clk);
            if (mem_we) dram[mem_a[7:0]] <= mem_d;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [31:0] mmem [256];
    int          m_last, m_owner, m_idle, m_g;
    logic [1:0]  m_rv, m_el, m_rdy;
    logic [31:0] m_rd [2];
    logic        m_to, m_to_n;
    logic [15:0] m_a;
    logic [31:0] m_d;
    logic        m_we;

    initial begin
        for (int i = 0; i < 256; i++) mmem[i] = 32'h0;
        mmem[8'h10] = 32'hDEADBEEF;
        mmem[8'h11] = 32'h0BADF00D;
        mmem[8'h30] = 32'h00000041;
    end

    // Per-cycle comparison against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_last = 1; m_owner = -1; m_idle = 0;
            m_rv = 2'b00; m_rd[0] = 32'h0; m_rd[1] = 32'h0; m_to = 1'b0;
        end else begin
            chk("model_rsp_valid", 64'(rsp_valid), 64'(m_rv));
            chk("model_rsp_rdata", rsp_rdata, {m_rd[1], m_rd[0]});
            chk("model_lock_timeout", 64'(lock_timeout), 64'(m_to));

            for (int i = 0; i < 2; i++)
                m_el[i] = req_valid[i] && !(m_rv[i] && !rsp_ready[i]) &&
                          (m_owner < 0 || m_owner == i);
            if (m_el == 2'b11)  m_g = 1 - m_last;
            else if (m_el[0])   m_g = 0;
            else if (m_el[1])   m_g = 1;
            else                m_g = -1;

            m_rdy = 2'b00; m_a = 16'h0; m_d = 32'h0; m_we = 1'b0;
            if (m_g >= 0) begin
                m_rdy[m_g] = 1'b1;
                m_a  = req_addr[m_g*16 +: 16];
                m_d  = req_wdata[m_g*32 +: 32];
                m_we = req_we[m_g];
            end
            chk("model_req_ready", 64'(req_ready), 64'(m_rdy));
            chk("model_mem_a", 64'(mem_a), 64'(m_a));
            chk("model_mem_d", 64'(mem_d), 64'(m_d));
            chk("model_mem_we", 64'(mem_we), 64'(m_we));

            m_to_n = 1'b0;
            for (int i = 0; i < 2; i++)
                if (m_rv[i] && rsp_ready[i]) m_rv[i] = 1'b0;
            if (m_g >= 0) begin
                m_rv[m_g] = 1'b1;
                m_rd[m_g] = mmem[m_a[7:0]];
                if (m_we) mmem[m_a[7:0]] = m_d;
                m_last  = m_g;
                m_idle  = 0;
                m_owner = req_lock[m_g] ? m_g : -1;
            end else if (m_owner >= 0) begin
                m_idle++;
                if (m_idle == LMAX) begin
                    m_last = m_owner; m_owner = -1; m_idle = 0; m_to_n = 1'b1;
                end
            end
            m_to = m_to_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00;
        req_addr = '0; req_wdata = '0; rsp_ready = 2'b11;

        // Reset values
        #2;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_mem_we", 64'(mem_we), 64'h0);
        chk("rst_lock_timeout", 64'(lock_timeout), 64'h0);
        #20 rst_n = 1'b1;
        tick();

        // 1: both read 0x10, grants alternate starting with port 0
        req_valid = 2'b11; req_addr = {16'h0010, 16'h0010};
        #1 chk("t1_ready0", 64'(req_ready), 64'h1);
        chk("t1_mem_a", 64'(mem_a), 64'h10);
        tick();
        chk("t1_rdata0", 64'(rsp_rdata[31:0]), 64'hDEADBEEF);
        chk("t1_ready1", 64'(req_ready), 64'h2);
        tick();
        chk("t1_rdata1", 64'(rsp_rdata[63:32]), 64'hDEADBEEF);
        chk("t1_ready2", 64'(req_ready), 64'h1);
        tick();
        chk("t1_ready3", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        tick();

        // 2: port 1 writes 0x20, port 0 reads it back
        req_valid = 2'b10; req_we = 2'b10; req_addr = {16'h0020, 16'h0000};
        req_wdata = {32'h12345678, 32'h0};
        #1 chk("t2_ready", 64'(req_ready), 64'h2);
        chk("t2_mem_we", 64'(mem_we), 64'h1);
        chk("t2_mem_d", 64'(mem_d), 64'h12345678);
        tick();
        chk("t2_wr_ack", 64'(rsp_rdata[63:32]), 64'h0);
        req_valid = 2'b01; req_we = 2'b00; req_addr = {16'h0000, 16'h0020};
        #1 chk("t2_rd_ready", 64'(req_ready), 64'h1);
        tick();
        chk("t2_rd_data", 64'(rsp_rdata[31:0]), 64'h12345678);

        // 3: port 0 response stalled, port 1 streams
        rsp_ready = 2'b10; req_valid = 2'b11; req_addr = {16'h0011, 16'h0010};
        for (int k = 0; k < 5; k++) begin
            #1 chk("t3_ready", 64'(req_ready), 64'h2);
            tick();
            chk("t3_hold0", 64'(rsp_rdata[31:0]), 64'h12345678);
            chk("t3_data1", 64'(rsp_rdata[63:32]), 64'h0BADF00D);
            chk("t3_valid", 64'(rsp_valid), 64'h3);
        end
        rsp_ready = 2'b11; req_valid = 2'b00;
        tick();

        // 4: locked read-modify-write by port 0 while port 1 waits
        req_valid = 2'b11; req_lock = 2'b01; req_addr = {16'h0011, 16'h0030};
        #1 chk("t4_lock_ready", 64'(req_ready), 64'h1);
        tick();
        chk("t4_rd", 64'(rsp_rdata[31:0]), 64'h41);
        req_we = 2'b01; req_lock = 2'b00; req_wdata = {32'h0, 32'h00000042};
        #1 chk("t4_wr_ready", 64'(req_ready), 64'h1);
        tick();
        chk("t4_wr_ack", 64'(rsp_rdata[31:0]), 64'h41);
        req_valid = 2'b10; req_we = 2'b00;
        #1 chk("t4_p1_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b01;
        #1 chk("t4_rb_ready", 64'(req_ready), 64'h1);
        tick();
        chk("t4_rb_data", 64'(rsp_rdata[31:0]), 64'h42);
        req_valid = 2'b00;
        tick();

        // 5: lock abandoned, timeout after LOCK_MAX idle cycles
        req_valid = 2'b01; req_lock = 2'b01; req_addr = {16'h0011, 16'h0010};
        #1 chk("t5_lock_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b10; req_lock = 2'b00;
        #1 chk("t5_blocked", 64'(req_ready), 64'h0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t5_no_to", 64'(lock_timeout), 64'h0);
            chk("t5_blocked_k", 64'(req_ready), 64'h0);
        end
        tick();
        chk("t5_timeout", 64'(lock_timeout), 64'h1);
        chk("t5_p1_ready", 64'(req_ready), 64'h2);
        tick();
        chk("t5_to_pulse", 64'(lock_timeout), 64'h0);
        chk("t5_p1_data", 64'(rsp_rdata[63:32]), 64'h0BADF00D);

        // 6: asynchronous reset in the middle of a lock
        rsp_ready = 2'b01; req_valid = 2'b01; req_lock = 2'b01;
        #1 chk("t6_lock_ready", 64'(req_ready), 64'h1);
        tick();
        chk("t6_valid_pre", 64'(rsp_valid), 64'h3);
        req_we = 2'b01; req_addr = {16'h0011, 16'h0040}; req_wdata = {32'h0, 32'h55};
        #1 chk("t6_we_pre", 64'(mem_we), 64'h1);
        chk("t6_ready_pre", 64'(req_ready), 64'h1);
        rst_n = 1'b0;
        #1 chk("t6_rst_valid", 64'(rsp_valid), 64'h0);
        chk("t6_rst_ready", 64'(req_ready), 64'h0);
        chk("t6_rst_we", 64'(mem_we), 64'h0);
        chk("t6_rst_a", 64'(mem_a), 64'h0);
        req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00; rsp_ready = 2'b11;
        req_addr = {16'h0011, 16'h0010};
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("t6_first", 64'(req_ready), 64'h1);
        tick();
        chk("t6_rdata0", 64'(rsp_rdata[31:0]), 64'hDEADBEEF);
        chk("t6_second", 64'(req_ready), 64'h2);
        tick();
        chk("t6_rdata1", 64'(rsp_rdata[63:32]), 64'h0BADF00D);
        req_valid = 2'b00;
        repeat (3) tick();
        chk("t6_no_write", 64'(dram[8'h40]), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
